// File: rtl/duty_cycle_multi_meter.sv
// Multi-channel duty-cycle / frequency meter.
// Each asynchronous input is synchronised. Over a fixed window of WINDOW clock
// cycles the block counts high samples and rising edges per channel. At the
// end of each window it publishes the counts with a one-cycle valid strobe.
module duty_cycle_multi_meter #(
  parameter int unsigned CHANNELS    = 4,
  parameter int unsigned WINDOW      = 65536,
  parameter int unsigned VALUE_W     = 17,
  parameter int unsigned EDGE_W      = 12,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        enable,
  input  logic [CHANNELS-1:0]         ring_in,
  output logic [CHANNELS*VALUE_W-1:0] high_count,
  output logic [CHANNELS*EDGE_W-1:0]  edge_count,
  output logic [CHANNELS-1:0]         stuck,
  output logic                        valid,
  output logic                        busy
);

  localparam int unsigned          ARM_W    = (SYNC_STAGES > 2) ? $clog2(SYNC_STAGES) : 1;
  localparam logic [ARM_W-1:0]     ARM_LAST = ARM_W'(SYNC_STAGES - 1);
  localparam logic [VALUE_W-1:0]   WIN_LAST = VALUE_W'(WINDOW - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARM,
    ST_MEASURE
  } state_e;

  state_e state_q, state_d;

  logic [CHANNELS-1:0] sync_q [SYNC_STAGES];
  logic [CHANNELS-1:0] s;

  logic [ARM_W-1:0]    arm_cnt_q, arm_cnt_d;
  logic [VALUE_W-1:0]  win_cnt_q, win_cnt_d;
  logic [CHANNELS-1:0] prev_q, prev_d;

  logic [VALUE_W-1:0]  hc_q      [CHANNELS];
  logic [VALUE_W-1:0]  hc_d      [CHANNELS];
  logic [VALUE_W-1:0]  hc_inc    [CHANNELS];
  logic [VALUE_W-1:0]  hc_snap_q [CHANNELS];
  logic [VALUE_W-1:0]  hc_snap_d [CHANNELS];

  logic [EDGE_W-1:0]   ec_q      [CHANNELS];
  logic [EDGE_W-1:0]   ec_d      [CHANNELS];
  logic [EDGE_W-1:0]   ec_inc    [CHANNELS];
  logic [EDGE_W-1:0]   ec_snap_q [CHANNELS];
  logic [EDGE_W-1:0]   ec_snap_d [CHANNELS];

  logic [CHANNELS-1:0] stuck_q, stuck_d;
  logic                valid_q, valid_d;

  logic                measuring;
  logic                arm_done;
  logic                win_end;

  // Synchroniser chain per channel; s is the last stage.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= '0;
      end
    end else begin
      sync_q[0] <= ring_in;
      for (int unsigned k = 1; k < SYNC_STAGES; k++) begin
        sync_q[k] <= sync_q[k-1];
      end
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: enable low from ARM or MEASURE aborts back to IDLE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (enable) state_d = ST_ARM;
      end
      ST_ARM: begin
        if (!enable)                     state_d = ST_IDLE;
        else if (arm_cnt_q == ARM_LAST)  state_d = ST_MEASURE;
      end
      ST_MEASURE: begin
        if (!enable) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs decoded from the state register only.
  always_comb begin
    busy      = 1'b0;
    measuring = 1'b0;
    arm_done  = 1'b0;
    unique case (state_q)
      ST_ARM: begin
        busy     = 1'b1;
        arm_done = (arm_cnt_q == ARM_LAST);
      end
      ST_MEASURE: begin
        busy      = 1'b1;
        measuring = 1'b1;
      end
      default: ;
    endcase
  end

  // Window timing and edge-detect history. A window that completes while
  // enable falls is still published because win_end ignores enable.
  always_comb begin
    win_end   = measuring && (win_cnt_q == WIN_LAST);
    arm_cnt_d = (state_q == ST_ARM) ? arm_cnt_q + ARM_W'(1) : '0;
    win_cnt_d = (measuring && !win_end) ? win_cnt_q + VALUE_W'(1) : '0;
    prev_d    = (measuring || arm_done) ? s : prev_q;
    valid_d   = win_end;
  end

  // Saturating per-channel increments including the current sample.
  always_comb begin
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      hc_inc[i] = (s[i] && (hc_q[i] != '1)) ? hc_q[i] + VALUE_W'(1) : hc_q[i];
      ec_inc[i] = (s[i] && !prev_q[i] && (ec_q[i] != '1)) ? ec_q[i] + EDGE_W'(1) : ec_q[i];
    end
  end

  // Working counters and snapshots. At window end the final sample goes into
  // the snapshot and the working counters restart from zero, so the sample of
  // the following cycle opens the next window with nothing dropped.
  always_comb begin
    stuck_d = stuck_q;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      hc_d[i]      = (measuring && !win_end) ? hc_inc[i] : '0;
      ec_d[i]      = (measuring && !win_end) ? ec_inc[i] : '0;
      hc_snap_d[i] = hc_snap_q[i];
      ec_snap_d[i] = ec_snap_q[i];
      if (win_end) begin
        hc_snap_d[i] = hc_inc[i];
        ec_snap_d[i] = ec_inc[i];
        stuck_d[i]   = (ec_inc[i] == '0);
      end
    end
  end

  // Control registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      arm_cnt_q <= '0;
      win_cnt_q <= '0;
      prev_q    <= '0;
      stuck_q   <= '0;
      valid_q   <= 1'b0;
    end else begin
      arm_cnt_q <= arm_cnt_d;
      win_cnt_q <= win_cnt_d;
      prev_q    <= prev_d;
      stuck_q   <= stuck_d;
      valid_q   <= valid_d;
    end
  end

  // Per-channel counter and snapshot registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        hc_q[i]      <= '0;
        ec_q[i]      <= '0;
        hc_snap_q[i] <= '0;
        ec_snap_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        hc_q[i]      <= hc_d[i];
        ec_q[i]      <= ec_d[i];
        hc_snap_q[i] <= hc_snap_d[i];
        ec_snap_q[i] <= ec_snap_d[i];
      end
    end
  end

  // Pack snapshot registers onto the output buses.
  always_comb begin
    high_count = '0;
    edge_count = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      high_count[i*VALUE_W +: VALUE_W] = hc_snap_q[i];
      edge_count[i*EDGE_W +: EDGE_W]   = ec_snap_q[i];
    end
  end

  assign stuck = stuck_q;
  assign valid = valid_q;

endmodule

// File: tb/tb_duty_cycle_multi_meter.sv
// Directed bench for duty_cycle_multi_meter: a 4-channel instance with a
// 16-cycle window and a 1-channel instance with narrow saturating counters.
module tb_duty_cycle_multi_meter;

  localparam int CH = 4;
  localparam int VW = 17;
  localparam int EW = 12;

  // Expected snapshot of the 4-channel instance for any full window:
  // ch0 toggle, ch1 high, ch2 low, ch3 high one cycle in four.
  localparam logic [CH*VW-1:0] EXP_HC    = {17'd4, 17'd0, 17'd16, 17'd8};
  localparam logic [CH*EW-1:0] EXP_EC    = {12'd4, 12'd0, 12'd0, 12'd8};
  localparam logic [CH-1:0]    EXP_STUCK = 4'b0110;

  logic              clk;
  logic              reset;
  logic              enable;
  logic [CH-1:0]     ring_in;
  logic [CH*VW-1:0]  high_count;
  logic [CH*EW-1:0]  edge_count;
  logic [CH-1:0]     stuck;
  logic              valid;
  logic              busy;

  logic              enable2;
  logic [0:0]        ring2;
  logic [3:0]        high_count2;
  logic [2:0]        edge_count2;
  logic [0:0]        stuck2;
  logic              valid2;
  logic              busy2;

  int total;
  int bad;
  int cyc;

  duty_cycle_multi_meter #(
    .CHANNELS(4), .WINDOW(16), .VALUE_W(17), .EDGE_W(12), .SYNC_STAGES(2)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .ring_in(ring_in),
    .high_count(high_count), .edge_count(edge_count), .stuck(stuck),
    .valid(valid), .busy(busy)
  );

  duty_cycle_multi_meter #(
    .CHANNELS(1), .WINDOW(15), .VALUE_W(4), .EDGE_W(3), .SYNC_STAGES(2)
  ) dut_sat (
    .clk(clk), .reset(reset), .enable(enable2), .ring_in(ring2),
    .high_count(high_count2), .edge_count(edge_count2), .stuck(stuck2),
    .valid(valid2), .busy(busy2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Free-running input patterns for the 4-channel instance.
  initial begin
    cyc = 0;
    ring_in = 4'b1010;
    forever begin
      @(negedge clk);
      cyc = cyc + 1;
      ring_in = {(cyc[1:0] == 2'b00), 1'b0, 1'b1, cyc[0]};
    end
  end

  task automatic test_reset;
    #2;
    total++; if (high_count !== '0) begin bad++; $display("FAIL reset_hc: got %h expected 0", high_count); end
    total++; if (edge_count !== '0) begin bad++; $display("FAIL reset_ec: got %h expected 0", edge_count); end
    total++; if (stuck !== 4'b0) begin bad++; $display("FAIL reset_stuck: got %b expected 0", stuck); end
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b expected 0", valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b expected 0", busy); end
    total++; if (busy2 !== 1'b0) begin bad++; $display("FAIL reset_busy2: got %b expected 0", busy2); end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL idle_busy: got %b expected 0", busy); end
  endtask

  task automatic test_basic;
    int n;
    int sum0;
    @(negedge clk);
    enable = 1'b1;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!valid && n < 100);
    total++; if (n !== 19) begin bad++; $display("FAIL first_latency: got %0d expected 19", n); end
    total++; if (high_count !== EXP_HC) begin bad++; $display("FAIL first_hc: got %h expected %h", high_count, EXP_HC); end
    total++; if (edge_count !== EXP_EC) begin bad++; $display("FAIL first_ec: got %h expected %h", edge_count, EXP_EC); end
    total++; if (stuck !== EXP_STUCK) begin bad++; $display("FAIL first_stuck: got %b expected %b", stuck, EXP_STUCK); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL first_busy: got %b expected 1", busy); end
    sum0 = int'(high_count[VW-1:0]);
    for (int w = 2; w <= 5; w++) begin
      n = 0;
      do begin @(posedge clk); #1; n++; end while (!valid && n < 100);
      total++; if (n !== 16) begin bad++; $display("FAIL window%0d_spacing: got %0d expected 16", w, n); end
      total++; if (high_count !== EXP_HC || edge_count !== EXP_EC) begin
        bad++; $display("FAIL window%0d_values: got hc=%h ec=%h expected hc=%h ec=%h", w, high_count, edge_count, EXP_HC, EXP_EC);
      end
      sum0 += int'(high_count[VW-1:0]);
    end
    total++; if (sum0 !== 40) begin bad++; $display("FAIL ch0_sum: got %0d expected 40", sum0); end
  endtask

  task automatic test_abort;
    int n;
    int pulses;
    repeat (7) @(posedge clk);
    @(negedge clk);
    enable = 1'b0;
    @(posedge clk); #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy: got %b expected 0", busy); end
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL abort_valid: got %b expected 0", valid); end
    pulses = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (valid) pulses++;
    end
    total++; if (pulses !== 0) begin bad++; $display("FAIL abort_pulses: got %0d expected 0", pulses); end
    total++; if (high_count !== EXP_HC || edge_count !== EXP_EC || stuck !== EXP_STUCK) begin
      bad++; $display("FAIL abort_hold: got hc=%h ec=%h expected hc=%h ec=%h", high_count, edge_count, EXP_HC, EXP_EC);
    end
    @(negedge clk);
    enable = 1'b1;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!valid && n < 100);
    total++; if (n !== 19) begin bad++; $display("FAIL reenable_latency: got %0d expected 19", n); end
    total++; if (high_count !== EXP_HC) begin bad++; $display("FAIL reenable_hc: got %h expected %h", high_count, EXP_HC); end
  endtask

  task automatic test_window_end_disable;
    repeat (15) @(posedge clk);
    @(negedge clk);
    enable = 1'b0;
    @(posedge clk); #1;
    total++; if (valid !== 1'b1) begin bad++; $display("FAIL wend_valid: got %b expected 1", valid); end
    total++; if (high_count !== EXP_HC || edge_count !== EXP_EC) begin
      bad++; $display("FAIL wend_values: got hc=%h ec=%h expected hc=%h ec=%h", high_count, edge_count, EXP_HC, EXP_EC);
    end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL wend_busy: got %b expected 0", busy); end
    @(posedge clk); #1;
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL wend_single: got %b expected 0", valid); end
  endtask

  task automatic test_async_reset;
    int n;
    @(negedge clk);
    enable = 1'b1;
    repeat (10) @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    total++; if (high_count !== '0 || edge_count !== '0) begin
      bad++; $display("FAIL areset_counts: got hc=%h ec=%h expected 0", high_count, edge_count);
    end
    total++; if (stuck !== 4'b0) begin bad++; $display("FAIL areset_stuck: got %b expected 0", stuck); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL areset_busy: got %b expected 0", busy); end
    @(negedge clk);
    reset = 1'b1;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!valid && n < 100);
    total++; if (n !== 19) begin bad++; $display("FAIL areset_latency: got %0d expected 19", n); end
    total++; if (high_count !== EXP_HC || edge_count !== EXP_EC || stuck !== EXP_STUCK) begin
      bad++; $display("FAIL areset_values: got hc=%h ec=%h expected hc=%h ec=%h", high_count, edge_count, EXP_HC, EXP_EC);
    end
    @(negedge clk);
    enable = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  // Toggle input, enable asserted with ring2=0: window 1 sees 8 highs and
  // 8 edges (edge count saturates at 7), window 2 sees 7 highs and 7 edges.
  task automatic test_saturation;
    int nv;
    nv = 0;
    for (int c = 0; c <= 40; c++) begin
      @(negedge clk);
      ring2 = (c % 2 == 1) ? 1'b1 : 1'b0;
      if (c == 0) enable2 = 1'b1;
      @(posedge clk); #1;
      if (valid2) begin
        nv++;
        if (nv == 1) begin
          total++; if (c !== 17) begin bad++; $display("FAIL sat_latency: got %0d expected 17", c); end
          total++; if (high_count2 !== 4'd8) begin bad++; $display("FAIL sat_hc1: got %0d expected 8", high_count2); end
          total++; if (edge_count2 !== 3'd7) begin bad++; $display("FAIL sat_ec1: got %0d expected 7", edge_count2); end
          total++; if (stuck2 !== 1'b0) begin bad++; $display("FAIL sat_stuck1: got %b expected 0", stuck2); end
        end else if (nv == 2) begin
          total++; if (c !== 32) begin bad++; $display("FAIL sat_spacing: got %0d expected 32", c); end
          total++; if (high_count2 !== 4'd7) begin bad++; $display("FAIL sat_hc2: got %0d expected 7", high_count2); end
          total++; if (edge_count2 !== 3'd7) begin bad++; $display("FAIL sat_ec2: got %0d expected 7", edge_count2); end
        end
      end
    end
    total++; if (nv !== 2) begin bad++; $display("FAIL sat_pulses: got %0d expected 2", nv); end
    @(negedge clk);
    enable2 = 1'b0;
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    reset   = 1'b0;
    enable  = 1'b0;
    enable2 = 1'b0;
    ring2   = 1'b0;
    test_reset;
    test_basic;
    test_abort;
    test_window_end_disable;
    test_async_reset;
    test_saturation;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
